// File: rtl/ppu_oam_ctrl.sv
// ppu_oam_ctrl -- sprite attribute memory (OAM) controller.
// Holds NUM_SPR x BYTES_PER_SPR bytes. After reset a sequencer clears the
// array one entry per cycle. Three clients share the array:
//   cpu_*  : pointer-based register port (auto-increment on data write)
//   dma_*  : burst write of DEPTH bytes starting at oam_ptr, valid/ready
//   ren_*  : independent renderer read port
// Ports:
//   clk, rst_n                    clock, async active-low reset
//   cpu_addr_wr/cpu_addr_in       load pointer
//   cpu_data_wr/cpu_wdata         write at pointer, then increment
//   cpu_data_rd                   read at pointer -> cpu_rdata/cpu_rvalid
//   oam_ptr                       current pointer
//   dma_start/dma_valid/dma_data  DMA request and byte stream
//   dma_ready/dma_done            accept strobe, completion pulse
//   ren_req/ren_addr              renderer read -> ren_rdata/ren_rvalid
//   busy                          clearing or DMA in progress
module ppu_oam_ctrl #(
   parameter int NUM_SPR       = 64,
   parameter int BYTES_PER_SPR = 4,
   parameter int DATA_W        = 8,
   parameter int MASK_ATTR     = 1,
   localparam int DEPTH        = NUM_SPR * BYTES_PER_SPR,
   localparam int AW           = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              cpu_addr_wr,
   input  logic [AW-1:0]     cpu_addr_in,
   input  logic              cpu_data_wr,
   input  logic              cpu_data_rd,
   input  logic [DATA_W-1:0] cpu_wdata,
   output logic [DATA_W-1:0] cpu_rdata,
   output logic              cpu_rvalid,
   output logic [AW-1:0]     oam_ptr,
   input  logic              dma_start,
   input  logic              dma_valid,
   input  logic [DATA_W-1:0] dma_data,
   output logic              dma_ready,
   output logic              dma_done,
   input  logic              ren_req,
   input  logic [AW-1:0]     ren_addr,
   output logic [DATA_W-1:0] ren_rdata,
   output logic              ren_rvalid,
   output logic              busy
);

   typedef enum logic [1:0] {ST_CLEAR, ST_IDLE, ST_DMA} state_t;

   state_t            state, state_d;
   logic [DATA_W-1:0] mem [DEPTH];
   logic [AW-1:0]     clr_cnt;
   logic [AW:0]       dma_cnt;
   logic [AW-1:0]     ptr_d;
   logic [AW-1:0]     cpu_wa;
   logic              mem_we;
   logic [AW-1:0]     mem_waddr;
   logic [DATA_W-1:0] mem_wdata;
   logic              dma_acc;
   logic              dma_last;
   logic              cpu_rd_go;

   function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
      return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   // Attribute byte bits [4:2] are unimplemented and read back as zero.
   function automatic logic [DATA_W-1:0] rd_mask(input logic [AW-1:0] a,
                                                 input logic [DATA_W-1:0] d);
      logic [DATA_W-1:0] r;
      r = d;
      if (MASK_ATTR != 0 && (a & AW'(BYTES_PER_SPR - 1)) == AW'(2))
         r[4:2] = '0;
      return r;
   endfunction

   assign dma_ready = (state == ST_DMA);
   assign busy      = (state != ST_IDLE);
   assign cpu_rd_go = cpu_data_rd & ~cpu_data_wr;

   always_comb begin
      state_d   = state;
      ptr_d     = oam_ptr;
      mem_we    = 1'b0;
      mem_waddr = oam_ptr;
      mem_wdata = '0;
      dma_acc   = 1'b0;
      dma_last  = 1'b0;
      cpu_wa    = cpu_addr_wr ? cpu_addr_in : oam_ptr;
      case (state)
         ST_CLEAR: begin
            mem_we    = 1'b1;
            mem_waddr = clr_cnt;
            if (clr_cnt == AW'(DEPTH - 1))
               state_d = ST_IDLE;
         end
         ST_IDLE: begin
            // A DMA start wins over a same-cycle CPU write so the burst
            // begins from a well-defined pointer.
            if (dma_start) begin
               state_d = ST_DMA;
            end else if (cpu_data_wr) begin
               mem_we    = 1'b1;
               mem_waddr = cpu_wa;
               mem_wdata = cpu_wdata;
               ptr_d     = ptr_inc(cpu_wa);
            end else if (cpu_addr_wr) begin
               ptr_d = cpu_addr_in;
            end
         end
         ST_DMA: begin
            dma_acc = dma_valid;
            if (dma_acc) begin
               mem_we    = 1'b1;
               mem_waddr = oam_ptr;
               mem_wdata = dma_data;
               ptr_d     = ptr_inc(oam_ptr);
               if (dma_cnt == (AW+1)'(DEPTH - 1)) begin
                  dma_last = 1'b1;
                  state_d  = ST_IDLE;
               end
            end
         end
         default: state_d = ST_CLEAR;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= ST_CLEAR;
         clr_cnt    <= '0;
         dma_cnt    <= '0;
         oam_ptr    <= '0;
         cpu_rdata  <= '0;
         cpu_rvalid <= 1'b0;
         ren_rdata  <= '0;
         ren_rvalid <= 1'b0;
         dma_done   <= 1'b0;
      end else begin
         state    <= state_d;
         oam_ptr  <= ptr_d;
         dma_done <= dma_last;
         if (state == ST_CLEAR)
            clr_cnt <= clr_cnt + 1'b1;
         if (state == ST_IDLE && dma_start)
            dma_cnt <= '0;
         else if (dma_acc)
            dma_cnt <= dma_cnt + 1'b1;
         cpu_rvalid <= cpu_rd_go;
         if (cpu_rd_go)
            cpu_rdata <= rd_mask(oam_ptr, mem[oam_ptr]);
         ren_rvalid <= ren_req;
         if (ren_req)
            ren_rdata <= rd_mask(ren_addr, mem[ren_addr]);
      end
   end

   // Array is not reset; the clear sequencer initialises it. Reads above use
   // the pre-edge contents, giving read-before-write on address collisions.
   always_ff @(posedge clk) begin
      if (mem_we)
         mem[mem_waddr] <= mem_wdata;
   end

endmodule

// File: tb/tb_ppu_oam_ctrl.sv
module tb_ppu_oam_ctrl;
   localparam int DEPTH = 256;
   localparam int AW    = 8;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          cpu_addr_wr = 1'b0, cpu_data_wr = 1'b0, cpu_data_rd = 1'b0;
   logic [AW-1:0] cpu_addr_in = '0;
   logic [7:0]    cpu_wdata = '0;
   logic          dma_start = 1'b0, dma_valid = 1'b0;
   logic [7:0]    dma_data = '0;
   logic          ren_req = 1'b0;
   logic [AW-1:0] ren_addr = '0;

   logic [7:0]    cpu_rdata, ren_rdata, cpu_rdata0, ren_rdata0;
   logic          cpu_rvalid, ren_rvalid, dma_ready, dma_done, busy;
   logic          cpu_rvalid0, ren_rvalid0, dma_ready0, dma_done0, busy0;
   logic [AW-1:0] oam_ptr, oam_ptr0;

   int unsigned vectors = 0;
   int unsigned miscompares = 0;

   // reference model
   logic [7:0] ref_mem [DEPTH];
   int         ref_ptr;
   logic [7:0] exp_cpu1, exp_cpu0;

   always #5 clk = ~clk;

   ppu_oam_ctrl dut (
      .clk(clk), .rst_n(rst_n),
      .cpu_addr_wr(cpu_addr_wr), .cpu_addr_in(cpu_addr_in),
      .cpu_data_wr(cpu_data_wr), .cpu_data_rd(cpu_data_rd),
      .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_rvalid(cpu_rvalid),
      .oam_ptr(oam_ptr), .dma_start(dma_start), .dma_valid(dma_valid),
      .dma_data(dma_data), .dma_ready(dma_ready), .dma_done(dma_done),
      .ren_req(ren_req), .ren_addr(ren_addr), .ren_rdata(ren_rdata),
      .ren_rvalid(ren_rvalid), .busy(busy)
   );

   ppu_oam_ctrl #(.MASK_ATTR(0)) dut_nomask (
      .clk(clk), .rst_n(rst_n),
      .cpu_addr_wr(cpu_addr_wr), .cpu_addr_in(cpu_addr_in),
      .cpu_data_wr(cpu_data_wr), .cpu_data_rd(cpu_data_rd),
      .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata0), .cpu_rvalid(cpu_rvalid0),
      .oam_ptr(oam_ptr0), .dma_start(dma_start), .dma_valid(dma_valid),
      .dma_data(dma_data), .dma_ready(dma_ready0), .dma_done(dma_done0),
      .ren_req(ren_req), .ren_addr(ren_addr), .ren_rdata(ren_rdata0),
      .ren_rvalid(ren_rvalid0), .busy(busy0)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Byte index 2 of each sprite reads with bits [4:2] forced to zero.
   function automatic logic [7:0] mdl_rd(input int addr, input bit mask_on);
      if (mask_on && (addr % 4) == 2)
         return ref_mem[addr] & 8'hE3;
      return ref_mem[addr];
   endfunction

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic mdl_reset;
      for (int i = 0; i < DEPTH; i++) ref_mem[i] = 8'h00;
      ref_ptr  = 0;
      exp_cpu1 = 8'h00;
      exp_cpu0 = 8'h00;
   endtask

   // One idle-state cycle on the CPU and renderer ports, checked against the model.
   task automatic step(input bit aw, input int ain, input bit dw, input logic [7:0] wd,
                       input bit rd, input bit rq, input int ra);
      bit         rv;
      int         a;
      logic [7:0] er1, er0;
      cpu_addr_wr = aw; cpu_addr_in = AW'(ain); cpu_data_wr = dw; cpu_wdata = wd;
      cpu_data_rd = rd; ren_req = rq; ren_addr = AW'(ra);
      rv = rd && !dw;
      if (rv) begin
         exp_cpu1 = mdl_rd(ref_ptr, 1'b1);
         exp_cpu0 = mdl_rd(ref_ptr, 1'b0);
      end
      er1 = mdl_rd(ra, 1'b1);
      er0 = mdl_rd(ra, 1'b0);
      if (dw) begin
         a = aw ? ain : ref_ptr;
         ref_mem[a] = wd;
         ref_ptr = (a + 1) % DEPTH;
      end else if (aw) begin
         ref_ptr = ain;
      end
      tick;
      cpu_addr_wr = 1'b0; cpu_data_wr = 1'b0; cpu_data_rd = 1'b0; ren_req = 1'b0;
      chk("cpu_rvalid", cpu_rvalid, rv);
      chk("cpu_rdata", cpu_rdata, exp_cpu1);
      chk("cpu_rdata_nomask", cpu_rdata0, exp_cpu0);
      chk("ren_rvalid", ren_rvalid, rq);
      if (rq) begin
         chk("ren_rdata", ren_rdata, er1);
         chk("ren_rdata_nomask", ren_rdata0, er0);
      end
      chk("oam_ptr", oam_ptr, ref_ptr);
   endtask

   task automatic ren_chk(input int ra);
      step(1'b0, 0, 1'b0, 8'h00, 1'b0, 1'b1, ra);
   endtask

   // Counts busy cycles after reset release; expects DEPTH and no dma_done.
   task automatic wait_clear;
      int n = 0;
      int d = 0;
      while (busy && n < 1000) begin
         n++;
         if (dma_done) d++;
         tick;
      end
      chk("clear_busy_cycles", n, DEPTH);
      chk("clear_no_dma_done", d, 0);
      chk("dma_ready_idle", dma_ready, 1'b0);
      mdl_reset();
   endtask

   task automatic start_dma;
      dma_start = 1'b1;
      tick;
      dma_start = 1'b0;
      chk("dma_busy", busy, 1'b1);
      chk("dma_ready_on", dma_ready, 1'b1);
   endtask

   initial begin
      int i, c, start;
      mdl_reset();
      // ---- reset state
      tick; tick;
      chk("rst_cpu_rdata", cpu_rdata, 8'h00);
      chk("rst_cpu_rvalid", cpu_rvalid, 1'b0);
      chk("rst_ren_rdata", ren_rdata, 8'h00);
      chk("rst_ren_rvalid", ren_rvalid, 1'b0);
      chk("rst_dma_ready", dma_ready, 1'b0);
      chk("rst_dma_done", dma_done, 1'b0);
      chk("rst_oam_ptr", oam_ptr, 0);
      rst_n = 1'b1;
      // ---- 1: clear sequence
      wait_clear();
      ren_chk(0); ren_chk(100); ren_chk(255);
      // ---- 2: pointer wrap on CPU writes
      step(1'b1, 'hFE, 1'b0, 8'h00, 1'b0, 1'b0, 0);
      step(1'b0, 0, 1'b1, 8'h11, 1'b0, 1'b0, 0);
      step(1'b0, 0, 1'b1, 8'h22, 1'b0, 1'b0, 0);
      step(1'b0, 0, 1'b1, 8'h33, 1'b0, 1'b0, 0);
      chk("ptr_after_wrap", oam_ptr, 8'h01);
      ren_chk('hFE); ren_chk('hFF); ren_chk('h00);
      step(1'b1, 'hFF, 1'b0, 8'h00, 1'b0, 1'b0, 0);
      step(1'b0, 0, 1'b0, 8'h00, 1'b1, 1'b0, 0);
      chk("cpu_read_ff", cpu_rdata, 8'h22);
      // ---- random CPU/renderer traffic in idle
      for (int k = 0; k < 120; k++) begin
         bit aw, dw, rd, rq;
         int ra;
         aw = ($urandom % 4) == 0;
         dw = ($urandom % 3) == 0;
         rd = ($urandom % 3) == 0;
         rq = ($urandom % 2) == 0;
         ra = (($urandom % 4) == 0) ? ref_ptr : int'($urandom % DEPTH);
         step(aw, int'($urandom % DEPTH), dw, 8'($urandom), rd, rq, ra);
      end
      // ---- 3/4: DMA with bubbles, ignored CPU write and restart mid-burst
      step(1'b1, 'h10, 1'b0, 8'h00, 1'b0, 1'b0, 0);
      start = ref_ptr;
      start_dma();
      i = 0; c = 0;
      while (i < DEPTH && c < 2000) begin
         dma_valid = (c % 3) != 2;
         dma_data  = 8'(i);
         if (c == 40) begin
            cpu_data_wr = 1'b1; cpu_wdata = 8'hAA;
            cpu_addr_wr = 1'b1; cpu_addr_in = 8'h33; dma_start = 1'b1;
         end
         chk("dma_ready_during", dma_ready, 1'b1);
         tick;
         cpu_data_wr = 1'b0; cpu_addr_wr = 1'b0; dma_start = 1'b0;
         if (dma_valid) begin
            ref_mem[(start + i) % DEPTH] = 8'(i);
            ref_ptr = (ref_ptr + 1) % DEPTH;
            i++;
         end
         if (i < DEPTH) begin
            chk("dma_done_early", dma_done, 1'b0);
            chk("dma_ptr", oam_ptr, ref_ptr);
         end
         c++;
      end
      dma_valid = 1'b0;
      chk("dma_accepted", i, DEPTH);
      chk("dma_done_pulse", dma_done, 1'b1);
      chk("dma_ready_drop", dma_ready, 1'b0);
      chk("dma_busy_drop", busy, 1'b0);
      chk("dma_ptr_end", oam_ptr, 8'h10);
      tick;
      chk("dma_done_single", dma_done, 1'b0);
      tick;
      chk("dma_done_quiet", dma_done, 1'b0);
      for (int a = 0; a < DEPTH; a++) ren_chk(a);
      // ---- 5: attribute masking
      step(1'b1, 'h02, 1'b1, 8'hFF, 1'b0, 1'b0, 0);
      step(1'b1, 'h06, 1'b1, 8'hFF, 1'b0, 1'b0, 0);
      ren_chk('h02);
      chk("mask_ren_02", ren_rdata, 8'hE3);
      chk("nomask_ren_02", ren_rdata0, 8'hFF);
      step(1'b1, 'h06, 1'b0, 8'h00, 1'b0, 1'b0, 0);
      step(1'b0, 0, 1'b0, 8'h00, 1'b1, 1'b0, 0);
      chk("mask_cpu_06", cpu_rdata, 8'hE3);
      chk("nomask_cpu_06", cpu_rdata0, 8'hFF);
      // ---- 6: read-before-write collision
      step(1'b1, 'h20, 1'b1, 8'h5A, 1'b0, 1'b1, 'h20);
      chk("rbw_old", ren_rdata, 8'h10);
      ren_chk('h20);
      chk("rbw_new", ren_rdata, 8'h5A);
      // ---- 6: reset mid-DMA
      start_dma();
      i = 0; c = 0;
      dma_valid = 1'b1;
      while (i < 100 && c < 500) begin
         dma_data = 8'($urandom);
         tick;
         i++; c++;
      end
      rst_n = 1'b0;
      #1;
      chk("abort_dma_ready", dma_ready, 1'b0);
      chk("abort_busy", busy, 1'b1);
      chk("abort_dma_done", dma_done, 1'b0);
      chk("abort_cpu_rdata", cpu_rdata, 8'h00);
      dma_valid = 1'b0;
      tick; tick; tick;
      rst_n = 1'b1;
      wait_clear();
      chk("abort_ptr", oam_ptr, 0);
      ren_chk('h10); ren_chk('h50); ren_chk('h73); ren_chk('hFF);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule

// File: doc/ppu_oam_ctrl.md
Name: ppu_oam_ctrl

Overview:
Parametrised sprite attribute memory (OAM) controller for the PPU. It holds NUM_SPR x BYTES_PER_SPR bytes and serves three clients:
- CPU register-style port with an auto-incrementing pointer.
- Burst DMA write port with valid/ready handshake.
- Independent renderer read port.

After reset it clears the whole array with a sequencer, one entry per cycle. No tri-state outputs.

Parameters:
NUM_SPR, 64, number of sprite entries
BYTES_PER_SPR, 4, bytes per sprite (power of 2)
DATA_W, 8, byte width
MASK_ATTR, 1, when 1, attribute byte (byte index 2) bits [4:2] read back as 0
(derived) DEPTH = NUM_SPR*BYTES_PER_SPR; AW = clog2(DEPTH)

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
cpu_addr_wr  in  1  load OAM pointer from cpu_addr_in
cpu_addr_in  in  AW  new pointer value
cpu_data_wr  in  1  write cpu_wdata at pointer, then increment pointer
cpu_data_rd  in  1  read byte at pointer (no increment)
cpu_wdata  in  DATA_W  CPU write data
cpu_rdata  out  DATA_W  CPU read data
cpu_rvalid  out  1  one-cycle pulse, cpu_rdata valid
oam_ptr  out  AW  current pointer
dma_start  in  1  request DMA burst of DEPTH bytes
dma_valid  in  1  dma_data valid
dma_data  in  DATA_W  DMA byte
dma_ready  out  1  controller accepts DMA byte this cycle
dma_done  out  1  one-cycle pulse after last DMA byte written
ren_req  in  1  renderer read request
ren_addr  in  AW  renderer byte address
ren_rdata  out  DATA_W  renderer read data
ren_rvalid  out  1  one-cycle pulse, ren_rdata valid
busy  out  1  state != IDLE

Behaviour:

States and transitions:
- States: CLEAR, IDLE, DMA.
- Reset: state = CLEAR, clr_cnt = 0, oam_ptr = 0. All outputs 0: cpu_rdata, cpu_rvalid, ren_rdata, ren_rvalid, dma_ready, dma_done.
- CLEAR: writes 0 to entry clr_cnt each cycle and increments clr_cnt. Goes to IDLE after writing entry DEPTH-1, so busy is high for exactly DEPTH cycles after reset release.
- IDLE: dma_start = 1 -> DMA. Byte counter = 0, start address = oam_ptr.
- DMA: dma_ready = 1. Each cycle with dma_valid & dma_ready:
  - writes dma_data at oam_ptr;
  - increments oam_ptr modulo DEPTH;
  - increments the byte counter.
- DMA completion: when the counter reaches DEPTH, dma_done pulses for 1 cycle in the cycle after the last write, dma_ready drops that same cycle, and state -> IDLE. oam_ptr ends equal to its start value, since it wraps. Bubbles (dma_valid = 0) stall without penalty.
- dma_start in CLEAR or DMA: ignored.

CPU port:
- Any CPU write (cpu_addr_wr or cpu_data_wr) in CLEAR or DMA is dropped; oam_ptr is unchanged.
- cpu_addr_wr: oam_ptr <= cpu_addr_in next cycle.
- cpu_data_wr alone: mem[oam_ptr] <= cpu_wdata; oam_ptr <= oam_ptr+1 mod DEPTH (DEPTH-1 wraps to 0).
- cpu_addr_wr and cpu_data_wr in the same cycle: write goes to cpu_addr_in; oam_ptr <= cpu_addr_in+1.
- cpu_data_rd: cpu_rdata = mem[oam_ptr] (masked) with cpu_rvalid one cycle later (latency 1). Reads are allowed in all states; in CLEAR they return the current array contents.
- cpu_data_rd together with cpu_data_wr: write performed, read ignored, no rvalid.
- cpu_rdata holds its last value when not reading.

Renderer port:
- ren_req: ren_rdata = mem[ren_addr] (masked), ren_rvalid after 1 cycle, in every state.
- Read-before-write: a same-cycle write to the same address returns old data.

Masking:
- Applies only to read data, when MASK_ATTR = 1 and byte index (addr mod BYTES_PER_SPR) == 2.
- Storage keeps all bits.

Reset mid-operation:
- Asserting rst_n low in DMA or CLEAR aborts immediately.
- After release, a full CLEAR restarts; no dma_done is emitted.

Test Plan:
1. Release reset, hold all inputs 0 -> busy = 1 for exactly 256 cycles (defaults), then 0; renderer reads of addresses 0, 100, 255 return 0x00.
2. cpu_addr_wr with 0xFE; cpu_data_wr 0x11, 0x22, 0x33 -> mem[0xFE] = 0x11, mem[0xFF] = 0x22, mem[0x00] = 0x33; oam_ptr = 0x01.
3. oam_ptr = 0x10; dma_start; stream bytes i = 0..255 with dma_valid deasserted every 3rd cycle -> mem[(0x10+i)%256] = i; dma_done single pulse after the 256th accept; oam_ptr = 0x10; busy back to 0.
4. During DMA, cpu_data_wr 0xAA and dma_start -> both ignored; DMA contents unchanged; only one dma_done.
5. Write 0xFF to address 0x02 and 0x06 -> CPU and renderer reads return 0xE3. With MASK_ATTR = 0, reads return 0xFF.
6. Same cycle: CPU write 0x5A at 0x20 and ren_req at 0x20 -> ren_rdata = old value. Reset asserted mid-DMA (byte 100) -> dma_ready = 0, busy held 256 cycles of CLEAR, no dma_done.
